gray_codec_pipe: RTL



---
 rtl/gray_codec_pkg.sv | 30 +++
 rtl/gray_codec_stage.sv | 71 +++++++
 rtl/gray_codec_pipe.sv | 65 ++++++
 3 files changed

// File: rtl/gray_codec_pkg.sv
// Shared definitions for the pipelined Gray/binary converter.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: mode encodings and the helpers that split the Gray->binary
// prefix-XOR chain into per-stage chunks of bit positions.
package gray_codec_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Bits resolved per stage: ceil(width / stages).
    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Highest bit resolved by stage s. Negative for trailing stages that
    // have nothing left to resolve (only when stages*chunk > width).
    function automatic int chunk_hi(input int width, input int stages, input int s);
        return width - 1 - s * chunk_size(width, stages);
    endfunction

    // Lowest bit resolved by stage s, clamped at bit 0.
    function automatic int chunk_lo(input int width, input int stages, input int s);
        int lo;
        lo = width - (s + 1) * chunk_size(width, stages);
        return (lo < 0) ? 0 : lo;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline stage of the Gray/binary converter plus its slice of the XOR chain.
// Latency: 1 cycle (registered output).
// Backpressure: holds all state while en is low; rst clears regardless of en.
//
// Ports: clk, rst (sync, active-high), en (shift enable), in_valid/in_mode/
// in_word from the previous stage, out_valid/out_mode/out_word registered.
// The word carries both kinds of bits: bits above the resolved boundary are
// already binary, bits below are still raw Gray, so the last resolved bit
// the next stage needs is simply word[hi+1].
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_word
);

    localparam int HI = chunk_hi(WIDTH, STAGES, IDX);
    localparam int LO = chunk_lo(WIDTH, STAGES, IDX);

    logic             r_valid;
    logic             r_mode;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word;

    always_comb begin
        w_word = in_word;
        if (in_mode == MODE_B2G) begin
            // Binary->Gray is a single XOR layer, done entirely up front.
            if (IDX == 0) begin
                w_word = in_word ^ (in_word >> 1);
            end
        end else begin
            // MSB of binary equals MSB of Gray, so the chain starts one
            // below it. Walking downward lets each bit see its binary
            // neighbour, whether resolved here or in an earlier stage.
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    w_word[i] = w_word[i+1] ^ in_word[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_G2B;
            r_word  <= '0;
        end else if (en) begin
            r_valid <= in_valid;
            r_mode  <= in_mode;
            r_word  <= w_word;
        end
    end

    assign out_valid = r_valid;
    assign out_mode  = r_mode;
    assign out_word  = r_word;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined, per-word-mode Gray<->binary converter with valid/ready streaming.
// Latency: STAGES cycles from accept to out_valid; 1 word/cycle with out_ready high.
// Backpressure: in_ready = !out_valid || out_ready; whole pipe stalls together, no bubble collapsing.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_data
// upstream; out_valid/out_ready/out_data/out_mode downstream; busy = any
// stage holds a word. in_mode 0 = Gray->binary, 1 = binary->Gray.
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             busy
);

    // Index 0 is the input port, index s+1 is the output of stage s.
    logic [STAGES:0]  w_vld;
    logic [STAGES:0]  w_mode;
    logic [WIDTH-1:0] w_word [0:STAGES];
    logic             w_shift;

    assign w_vld[0]  = in_valid;
    assign w_mode[0] = in_mode;
    assign w_word[0] = in_data;

    // A single global enable: the pipe only moves when the output slot is
    // empty or being drained, so every stage either shifts or holds.
    assign in_ready = !out_valid || out_ready;
    assign w_shift  = in_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        gray_codec_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (g)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (w_shift),
            .in_valid  (w_vld[g]),
            .in_mode   (w_mode[g]),
            .in_word   (w_word[g]),
            .out_valid (w_vld[g+1]),
            .out_mode  (w_mode[g+1]),
            .out_word  (w_word[g+1])
        );
    end

    assign out_valid = w_vld[STAGES];
    assign out_mode  = w_mode[STAGES];
    assign out_data  = w_word[STAGES];
    assign busy      = |w_vld[STAGES:1];

endmodule
